// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - decode-stage handshake, regfile and result-bus signal bundle with ALU code macros
`ifndef INST_ALU_CODES
`define INST_ALU_CODES
`define ALU_OP_W              8
`define ALU_CAT_W             3
`define INST_NOP_OPERATOR     8'h00
`define INST_AND_OPERATOR     8'h01
`define INST_OR_OPERATOR      8'h02
`define INST_XOR_OPERATOR     8'h03
`define INST_NOR_OPERATOR     8'h04
`define INST_LUI_OPERATOR     8'h05
`define INST_SLL_OPERATOR     8'h06
`define INST_SRL_OPERATOR     8'h07
`define INST_SRA_OPERATOR     8'h08
`define INST_NOP_CATEGORY     3'h0
`define INST_LOGIC_CATEGORY   3'h1
`define INST_SHIFT_CATEGORY   3'h2
`endif

interface id_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_W-1:0]       program_counter;
    logic [INST_W-1:0]       instruction;
    logic                    read_enable1;
    logic                    read_enable2;
    logic [REG_ADDR_W-1:0]   read_addr1;
    logic [REG_ADDR_W-1:0]   read_addr2;
    logic [DATA_W-1:0]       read_result1;
    logic [DATA_W-1:0]       read_result2;
    logic                    ex_write_enable;
    logic [REG_ADDR_W-1:0]   ex_write_addr;
    logic [DATA_W-1:0]       ex_write_data;
    logic                    ex_is_load;
    logic                    mem_write_enable;
    logic [REG_ADDR_W-1:0]   mem_write_addr;
    logic [DATA_W-1:0]       mem_write_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [`ALU_OP_W-1:0]    alu_operator;
    logic [`ALU_CAT_W-1:0]   alu_category;
    logic [DATA_W-1:0]       alu_operand1;
    logic [DATA_W-1:0]       alu_operand2;
    logic                    write_enable;
    logic [REG_ADDR_W-1:0]   write_addr;
    logic [ADDR_W-1:0]       out_pc;
    logic                    illegal;

    modport slave (
        input  in_valid, program_counter, instruction,
        input  read_result1, read_result2,
        input  ex_write_enable, ex_write_addr, ex_write_data, ex_is_load,
        input  mem_write_enable, mem_write_addr, mem_write_data,
        input  flush, out_ready,
        output in_ready, read_enable1, read_enable2, read_addr1, read_addr2,
        output out_valid, alu_operator, alu_category, alu_operand1, alu_operand2,
        output write_enable, write_addr, out_pc, illegal
    );

    modport master (
        output in_valid, program_counter, instruction,
        output read_result1, read_result2,
        output ex_write_enable, ex_write_addr, ex_write_data, ex_is_load,
        output mem_write_enable, mem_write_addr, mem_write_data,
        output flush, out_ready,
        input  in_ready, read_enable1, read_enable2, read_addr1, read_addr2,
        input  out_valid, alu_operator, alu_category, alu_operand1, alu_operand2,
        input  write_enable, write_addr, out_pc, illegal
    );
endinterface

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - registered MIPS logic/shift decode stage with hazard handling; ID_FORWARD_EN enables EX/MEM forwarding
module id_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic        clock,
    input  logic        reset,
    id_pipe_if.slave    bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;

    // operand source selectors
    typedef enum logic [1:0] {SRC1_ZERO, SRC1_REG, SRC1_SA, SRC1_LUI} src1_e;
    typedef enum logic [1:0] {SRC2_ZERO, SRC2_REG, SRC2_IMM}          src2_e;

    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic [REG_ADDR_W-1:0]  rs;
    logic [REG_ADDR_W-1:0]  rt;
    logic [REG_ADDR_W-1:0]  rd;
    logic [4:0]             sa;
    logic [15:0]            imm;

    assign opcode = bus.instruction[31:26];
    assign rs     = bus.instruction[25:21];
    assign rt     = bus.instruction[20:16];
    assign rd     = bus.instruction[15:11];
    assign sa     = bus.instruction[10:6];
    assign funct  = bus.instruction[5:0];
    assign imm    = bus.instruction[15:0];

    logic                   re1_d;
    logic                   re2_d;
    logic                   we_d;
    logic [REG_ADDR_W-1:0]  waddr_d;
    logic [`ALU_OP_W-1:0]   op_d;
    logic [`ALU_CAT_W-1:0]  cat_d;
    logic                   illegal_d;
    src1_e                  src1_d;
    src2_e                  src2_d;

    // instruction decode: read ports, destination, ALU codes and operand sources
    always_comb begin
        re1_d     = 1'b0;
        re2_d     = 1'b0;
        we_d      = 1'b0;
        waddr_d   = '0;
        op_d      = `INST_NOP_OPERATOR;
        cat_d     = `INST_NOP_CATEGORY;
        illegal_d = 1'b0;
        src1_d    = SRC1_ZERO;
        src2_d    = SRC2_ZERO;
        unique case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                re1_d   = 1'b1;
                we_d    = 1'b1;
                waddr_d = rt;
                cat_d   = `INST_LOGIC_CATEGORY;
                src1_d  = SRC1_REG;
                src2_d  = SRC2_IMM;
                op_d    = (opcode == OP_ANDI) ? `INST_AND_OPERATOR :
                          (opcode == OP_ORI)  ? `INST_OR_OPERATOR  : `INST_XOR_OPERATOR;
            end
            OP_LUI: begin
                // LUI's rs field carries no operand, so no read and no hazard
                we_d    = 1'b1;
                waddr_d = rt;
                cat_d   = `INST_LOGIC_CATEGORY;
                op_d    = `INST_LUI_OPERATOR;
                src1_d  = SRC1_LUI;
            end
            OP_SPECIAL: begin
                unique case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        re1_d   = 1'b1;
                        re2_d   = 1'b1;
                        we_d    = 1'b1;
                        waddr_d = rd;
                        cat_d   = `INST_LOGIC_CATEGORY;
                        src1_d  = SRC1_REG;
                        src2_d  = SRC2_REG;
                        op_d    = (funct == FN_AND) ? `INST_AND_OPERATOR :
                                  (funct == FN_OR)  ? `INST_OR_OPERATOR  :
                                  (funct == FN_XOR) ? `INST_XOR_OPERATOR : `INST_NOR_OPERATOR;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        re2_d   = 1'b1;
                        we_d    = 1'b1;
                        waddr_d = rd;
                        cat_d   = `INST_SHIFT_CATEGORY;
                        src1_d  = SRC1_SA;
                        src2_d  = SRC2_REG;
                        op_d    = (funct == FN_SLL) ? `INST_SLL_OPERATOR :
                                  (funct == FN_SRL) ? `INST_SRL_OPERATOR : `INST_SRA_OPERATOR;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    logic re1;
    logic re2;
    assign re1 = bus.in_valid && re1_d;
    assign re2 = bus.in_valid && re2_d;

    assign bus.read_enable1 = re1;
    assign bus.read_enable2 = re2;
    assign bus.read_addr1   = rs;
    assign bus.read_addr2   = rt;

    logic [DATA_W-1:0] reg1_val;
    logic [DATA_W-1:0] reg2_val;
    logic              stall;

`ifdef ID_FORWARD_EN
    // operand bypass: $0 reads zero, EX result beats MEM result beats regfile
    always_comb begin
        reg1_val = bus.read_result1;
        reg2_val = bus.read_result2;
        if (rs == '0)
            reg1_val = '0;
        else if (bus.ex_write_enable && bus.ex_write_addr == rs)
            reg1_val = bus.ex_write_data;
        else if (bus.mem_write_enable && bus.mem_write_addr == rs)
            reg1_val = bus.mem_write_data;
        if (rt == '0)
            reg2_val = '0;
        else if (bus.ex_write_enable && bus.ex_write_addr == rt)
            reg2_val = bus.ex_write_data;
        else if (bus.mem_write_enable && bus.mem_write_addr == rt)
            reg2_val = bus.mem_write_data;
    end

    // only a load in EX cannot be bypassed yet
    always_comb begin
        stall = 1'b0;
        if (bus.ex_is_load && bus.ex_write_enable && bus.ex_write_addr != '0) begin
            if ((re1 && bus.ex_write_addr == rs) || (re2 && bus.ex_write_addr == rt))
                stall = 1'b1;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_write_data, bus.mem_write_data, bus.ex_is_load};

    // without bypass every operand comes straight from the regfile
    always_comb begin
        reg1_val = bus.read_result1;
        reg2_val = bus.read_result2;
    end

    // any pending EX/MEM write to a source register must drain first
    always_comb begin
        stall = 1'b0;
        if (re1 && rs != '0 &&
            ((bus.ex_write_enable && bus.ex_write_addr == rs) ||
             (bus.mem_write_enable && bus.mem_write_addr == rs)))
            stall = 1'b1;
        if (re2 && rt != '0 &&
            ((bus.ex_write_enable && bus.ex_write_addr == rt) ||
             (bus.mem_write_enable && bus.mem_write_addr == rt)))
            stall = 1'b1;
    end
`endif

    logic [DATA_W-1:0] op1_d;
    logic [DATA_W-1:0] op2_d;

    // final operand muxes from the decoded sources
    always_comb begin
        op1_d = '0;
        op2_d = '0;
        unique case (src1_d)
            SRC1_REG: op1_d = reg1_val;
            SRC1_SA:  op1_d = {{(DATA_W-5){1'b0}}, sa};
            SRC1_LUI: op1_d = {imm, {(DATA_W-16){1'b0}}};
            default:  op1_d = '0;
        endcase
        unique case (src2_d)
            SRC2_REG: op2_d = reg2_val;
            SRC2_IMM: op2_d = {{(DATA_W-16){1'b0}}, imm};
            default:  op2_d = '0;
        endcase
    end

    logic                   out_valid_q;
    logic [`ALU_OP_W-1:0]   op_q;
    logic [`ALU_CAT_W-1:0]  cat_q;
    logic [DATA_W-1:0]      op1_q;
    logic [DATA_W-1:0]      op2_q;
    logic                   we_q;
    logic [REG_ADDR_W-1:0]  waddr_q;
    logic [ADDR_W-1:0]      pc_q;
    logic                   illegal_q;

    logic advance;
    logic transfer;
    assign advance      = !out_valid_q || bus.out_ready;
    assign transfer     = bus.in_valid && !stall && advance;
    assign bus.in_ready = !reset && (bus.flush || (!stall && advance));

    // ID/EX register: reset, then flush, then advance; otherwise hold
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            op_q        <= `INST_NOP_OPERATOR;
            cat_q       <= `INST_NOP_CATEGORY;
            op1_q       <= '0;
            op2_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (advance) begin
            out_valid_q <= transfer;
            if (transfer) begin
                op_q      <= op_d;
                cat_q     <= cat_d;
                op1_q     <= op1_d;
                op2_q     <= op2_d;
                we_q      <= we_d;
                waddr_q   <= waddr_d;
                pc_q      <= bus.program_counter;
                illegal_q <= illegal_d;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.alu_operator = op_q;
    assign bus.alu_category = cat_q;
    assign bus.alu_operand1 = op1_q;
    assign bus.alu_operand2 = op2_q;
    assign bus.write_enable = we_q;
    assign bus.write_addr   = waddr_q;
    assign bus.out_pc       = pc_q;
    assign bus.illegal      = illegal_q;
endmodule
